// File: rtl/dpwm_capture.sv
// dpwm_capture
//   Taps the complementary gate-drive pair c1/c2 of the DPWM and decodes it back
//   into one record per switching cycle: c1 on-time, dead-time c1->c2, c2 on-time,
//   dead-time c2->c1 and their sum. Also flags shoot-through, edge-order errors
//   and a stalled waveform. Same clock domain as the DPWM.
//
// Ports
//   i_clk      system clock (DPWM clock)
//   reset      asynchronous reset, active low
//   i_en       capture enable; low forces IDLE, outputs and flags hold
//   i_clr      one-cycle pulse, clears o_overlap / o_seq_err
//   i_c1,i_c2  gate signals, synchronous to i_clk
//   o_ton      c1 high cycles            o_dt1   both-low cycles, c1 fall -> c2 rise
//   o_toff2    c2 high cycles            o_dt2   both-low cycles, c2 fall -> c1 rise
//   o_period   sum of the four (saturated) fields
//   o_valid    one-cycle pulse, new record on the outputs
//   o_sat      record had at least one saturated field (qualified by o_valid)
//   o_overlap  sticky, c1 and c2 sampled high together
//   o_seq_err  sticky, edge order violated
//   o_stall    one-cycle pulse, a phase reached TIMEOUT
module dpwm_capture #(
  parameter int TON_W   = 11,
  parameter int DT_W    = 5,
  parameter int PER_W   = 13,
  parameter int TIMEOUT = 4095
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_c1,
  input  logic             i_c2,
  output logic [TON_W-1:0] o_ton,
  output logic [DT_W-1:0]  o_dt1,
  output logic [TON_W-1:0] o_toff2,
  output logic [DT_W-1:0]  o_dt2,
  output logic [PER_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_sat,
  output logic             o_overlap,
  output logic             o_seq_err,
  output logic             o_stall
);

  localparam int CNT_W  = PER_W - 1;
  localparam int STAGES = 1;

  localparam logic [CNT_W-1:0] TON_MAX = CNT_W'((1 << TON_W) - 1);
  localparam logic [CNT_W-1:0] DT_MAX  = CNT_W'((1 << DT_W) - 1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_C1H  = 3'd1;
  localparam logic [2:0] ST_DT1  = 3'd2;
  localparam logic [2:0] ST_C2H  = 3'd3;
  localparam logic [2:0] ST_DT2  = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2, p1;
  // vld_pipe[0]: s1 holds a real sample; vld_pipe[1]: p1 holds a real sample.
  // Keeps a c1 that is already high at reset release from looking like a rise.
  logic [STAGES:0]  vld_pipe;

  // Fields of the record under construction, already saturated
  logic [TON_W-1:0] ton_r, toff2_r;
  logic [DT_W-1:0]  dt1_r;
  logic             sat_r;

  logic             c1_rise;
  logic [CNT_W-1:0] cnt_inc;
  logic [TON_W-1:0] ton_fit;
  logic [DT_W-1:0]  dt_fit;
  logic             ton_ovf, dt_ovf;
  logic [PER_W-1:0] period_nxt;

  always_comb begin
    c1_rise    = s1 & ~p1 & vld_pipe[STAGES];
    cnt_inc    = (cnt == CNT_TO) ? cnt : cnt + CNT_ONE;
    ton_ovf    = (cnt > TON_MAX);
    dt_ovf     = (cnt > DT_MAX);
    ton_fit    = ton_ovf ? {TON_W{1'b1}} : cnt[TON_W-1:0];
    dt_fit     = dt_ovf  ? {DT_W{1'b1}}  : cnt[DT_W-1:0];
    // Closing dead-time goes straight from the counter into the sum
    period_nxt = PER_W'(ton_r) + PER_W'(dt1_r) + PER_W'(toff2_r) + PER_W'(dt_fit);
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      p1        <= 1'b0;
      vld_pipe  <= '0;
      state     <= ST_IDLE;
      cnt       <= '0;
      ton_r     <= '0;
      dt1_r     <= '0;
      toff2_r   <= '0;
      sat_r     <= 1'b0;
      o_ton     <= '0;
      o_dt1     <= '0;
      o_toff2   <= '0;
      o_dt2     <= '0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_sat     <= 1'b0;
      o_overlap <= 1'b0;
      o_seq_err <= 1'b0;
      o_stall   <= 1'b0;
    end else begin
      s1       <= i_c1;
      s2       <= i_c2;
      p1       <= s1;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      o_valid  <= 1'b0;
      o_stall  <= 1'b0;

      // Clear first so a set in the same cycle (later assignment) wins
      if (i_clr) begin
        o_overlap <= 1'b0;
        o_seq_err <= 1'b0;
      end

      if (!i_en) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (s1 && s2) begin
        // Shoot-through beats every other transition
        o_overlap <= 1'b1;
        state     <= ST_IDLE;
        cnt       <= '0;
      end else if (state != ST_IDLE && cnt == CNT_TO) begin
        o_stall <= 1'b1;
        state   <= ST_IDLE;
        cnt     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (c1_rise) begin
              cnt   <= CNT_ONE;
              state <= ST_C1H;
            end
          end
          ST_C1H: begin
            if (s1) begin
              cnt <= cnt_inc;
            end else begin
              ton_r <= ton_fit;
              sat_r <= ton_ovf;
              cnt   <= CNT_ONE;
              state <= ST_DT1;
            end
          end
          ST_DT1: begin
            if (s2) begin
              dt1_r <= dt_fit;
              sat_r <= sat_r | dt_ovf;
              cnt   <= CNT_ONE;
              state <= ST_C2H;
            end else if (s1) begin
              // c1 came back before c2: drop this record, the new c1 pulse starts the next
              o_seq_err <= 1'b1;
              cnt       <= CNT_ONE;
              state     <= ST_C1H;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_C2H: begin
            if (s2) begin
              cnt <= cnt_inc;
            end else begin
              toff2_r <= ton_fit;
              sat_r   <= sat_r | ton_ovf;
              cnt     <= CNT_ONE;
              state   <= ST_DT2;
            end
          end
          ST_DT2: begin
            if (s1) begin
              // Closing c1 rise is also the opening edge of the next record
              o_ton    <= ton_r;
              o_dt1    <= dt1_r;
              o_toff2  <= toff2_r;
              o_dt2    <= dt_fit;
              o_period <= period_nxt;
              o_sat    <= sat_r | dt_ovf;
              o_valid  <= 1'b1;
              cnt      <= CNT_ONE;
              state    <= ST_C1H;
            end else if (s2) begin
              o_seq_err <= 1'b1;
              cnt       <= '0;
              state     <= ST_IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpwm_capture.sv
// Directed + randomized bench for dpwm_capture. Waveforms are built from
// segment lengths; the expected record of every complete switching cycle is
// derived from those lengths and queued with the sample step at which it must
// appear on the outputs.
module tb_dpwm_capture;
  logic        i_clk = 1'b0;
  logic        reset, i_en, i_clr, i_c1, i_c2;
  logic [10:0] o_ton, o_toff2;
  logic [4:0]  o_dt1, o_dt2;
  logic [12:0] o_period;
  logic        o_valid, o_sat, o_overlap, o_seq_err, o_stall;

  dpwm_capture dut (
    .i_clk(i_clk), .reset(reset), .i_en(i_en), .i_clr(i_clr),
    .i_c1(i_c1), .i_c2(i_c2),
    .o_ton(o_ton), .o_dt1(o_dt1), .o_toff2(o_toff2), .o_dt2(o_dt2),
    .o_period(o_period), .o_valid(o_valid), .o_sat(o_sat),
    .o_overlap(o_overlap), .o_seq_err(o_seq_err), .o_stall(o_stall)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int ton; int dt1; int toff2; int dt2; int due;
  } rec_t;

  int   errors = 0;
  int   checks = 0;
  int   step = 0;
  int   stall_cnt = 0;
  int   exp_stall_step = -1;
  rec_t q[$];
  rec_t prev;
  rec_t last;
  bit   have_prev = 0;

  function automatic int satv(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // One clock: drive inputs, sample #1 after the edge, check per-cycle outputs
  task automatic tick(input bit c1, input bit c2);
    rec_t r;
    bit   due_now;
    i_c1 = c1;
    i_c2 = c2;
    @(posedge i_clk);
    #1;
    step++;
    due_now = (q.size() > 0) && (q[0].due == step);
    chk("valid", o_valid, due_now);
    chk("stall", o_stall, step == exp_stall_step);
    if (o_stall) stall_cnt++;
    if (due_now) begin
      r = q.pop_front();
      chk("ton",    o_ton,    satv(r.ton, 11));
      chk("dt1",    o_dt1,    satv(r.dt1, 5));
      chk("toff2",  o_toff2,  satv(r.toff2, 11));
      chk("dt2",    o_dt2,    satv(r.dt2, 5));
      chk("period", o_period, satv(r.ton, 11) + satv(r.dt1, 5) + satv(r.toff2, 11) + satv(r.dt2, 5));
      chk("sat",    o_sat,    (r.ton > 2047) || (r.dt1 > 31) || (r.toff2 > 2047) || (r.dt2 > 31));
    end
  endtask

  task automatic seg(input bit c1, input bit c2, input int n);
    for (int i = 0; i < n; i++) tick(c1, c2);
  endtask

  // First c1-high cycle; it closes the previous complete cycle, if any.
  // The record shows up one sample after the edge that takes in this c1 rise.
  task automatic start_c1();
    rec_t r;
    if (have_prev) begin
      r     = prev;
      r.due = step + 2;
      q.push_back(r);
      last  = r;
    end
    have_prev = 0;
    tick(1'b1, 1'b0);
  endtask

  task automatic period(input int ton, input int dt1, input int toff2, input int dt2);
    start_c1();
    seg(1'b1, 1'b0, ton - 1);
    seg(1'b0, 1'b0, dt1);
    seg(1'b0, 1'b1, toff2);
    seg(1'b0, 1'b0, dt2);
    prev      = '{ton, dt1, toff2, dt2, 0};
    have_prev = 1;
  endtask

  // Publish the pending record, then park the capture in IDLE via i_en
  task automatic flush();
    start_c1();
    seg(1'b1, 1'b0, 3);
    i_en = 1'b0;
    seg(1'b0, 1'b0, 3);
    i_en = 1'b1;
    seg(1'b0, 1'b0, 2);
  endtask

  task automatic chk_last(input string tag);
    chk({tag, "_ton"},    o_ton,    satv(last.ton, 11));
    chk({tag, "_dt1"},    o_dt1,    satv(last.dt1, 5));
    chk({tag, "_toff2"},  o_toff2,  satv(last.toff2, 11));
    chk({tag, "_dt2"},    o_dt2,    satv(last.dt2, 5));
    chk({tag, "_period"}, o_period, satv(last.ton, 11) + satv(last.dt1, 5) +
                                    satv(last.toff2, 11) + satv(last.dt2, 5));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ton"},     o_ton,     0);
    chk({tag, "_dt1"},     o_dt1,     0);
    chk({tag, "_toff2"},   o_toff2,   0);
    chk({tag, "_dt2"},     o_dt2,     0);
    chk({tag, "_period"},  o_period,  0);
    chk({tag, "_valid"},   o_valid,   0);
    chk({tag, "_sat"},     o_sat,     0);
    chk({tag, "_overlap"}, o_overlap, 0);
    chk({tag, "_seq_err"}, o_seq_err, 0);
    chk({tag, "_stall"},   o_stall,   0);
  endtask

  initial begin
    int k;
    reset = 1'b0; i_en = 1'b1; i_clr = 1'b0; i_c1 = 1'b0; i_c2 = 1'b0;

    // Reset state
    seg(1'b0, 1'b0, 3);
    chk_zero("rst");
    reset = 1'b1;
    seg(1'b0, 1'b0, 4);

    // Steady 250-cycle waveform, back-to-back records
    period(100, 8, 130, 12);
    period(100, 8, 130, 12);
    period(100, 8, 130, 12);
    flush();
    chk_last("hold1");
    chk("ovl_clean", o_overlap, 0);
    chk("seq_clean", o_seq_err, 0);

    // Dead-time 2 over the field width
    period(100, 8, 130, 40);
    flush();
    chk("sat_dt2", o_dt2, 31);
    chk("sat_per", o_period, 269);
    chk("sat_flag", o_sat, 1);

    // Random waveforms, some dead-times saturating
    for (int i = 0; i < 15; i++)
      period($urandom_range(1, 200), $urandom_range(1, 40),
             $urandom_range(1, 200), $urandom_range(1, 40));
    flush();
    chk_last("hold_rnd");

    // Shoot-through during C1H
    period(60, 5, 60, 5);
    start_c1();
    seg(1'b1, 1'b0, 9);
    tick(1'b1, 1'b1);
    seg(1'b1, 1'b0, 10);
    seg(1'b0, 1'b0, 10);
    chk("ovl_set", o_overlap, 1);
    period(40, 3, 40, 3);
    period(50, 4, 50, 4);
    flush();
    chk("ovl_sticky", o_overlap, 1);
    chk_last("ovl_rec");
    i_clr = 1'b1;
    tick(1'b0, 1'b0);
    i_clr = 1'b0;
    chk("ovl_clr", o_overlap, 0);

    // Stalled c1
    seg(1'b0, 1'b0, 5);
    stall_cnt = 0;
    start_c1();
    k = step;
    exp_stall_step = k + 4096;
    seg(1'b1, 1'b0, 4999);
    chk("stall_once", stall_cnt, 1);
    exp_stall_step = -1;
    seg(1'b0, 1'b0, 10);
    period(77, 6, 88, 9);
    period(33, 2, 44, 3);
    flush();
    chk_last("post_stall");

    // Two c1 pulses without c2; the second one opens a fresh record
    chk("seq_pre", o_seq_err, 0);
    seg(1'b0, 1'b0, 5);
    start_c1();
    seg(1'b1, 1'b0, 19);
    seg(1'b0, 1'b0, 5);
    tick(1'b1, 1'b0);
    seg(1'b1, 1'b0, 19);
    seg(1'b0, 1'b0, 6);
    seg(1'b0, 1'b1, 30);
    seg(1'b0, 1'b0, 7);
    chk("seq_set", o_seq_err, 1);
    prev      = '{20, 6, 30, 7, 0};
    have_prev = 1;
    start_c1();
    seg(1'b1, 1'b0, 10);
    seg(1'b0, 1'b0, 4);
    seg(1'b0, 1'b1, 10);
    chk_last("seq_rec");
    // Async reset in the middle of a record
    reset = 1'b0;
    #1;
    chk_zero("mid_rst");
    seg(1'b0, 1'b1, 2);
    reset = 1'b1;
    have_prev = 0;
    seg(1'b0, 1'b1, 5);
    seg(1'b0, 1'b0, 5);
    period(90, 7, 70, 11);
    period(45, 3, 45, 3);
    flush();
    chk_last("post_rst");

    // c1 already high at reset release: the partial pulse is never measured
    reset = 1'b0;
    seg(1'b1, 1'b0, 3);
    reset = 1'b1;
    have_prev = 0;
    seg(1'b1, 1'b0, 30);
    seg(1'b0, 1'b0, 8);
    seg(1'b0, 1'b1, 50);
    seg(1'b0, 1'b0, 10);
    chk("early_none", o_ton, 0);
    period(66, 4, 55, 6);
    period(30, 2, 30, 2);
    flush();
    chk_last("early_rec");

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
